// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants used by fetch and decode.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mips_pkg;

  localparam int INSTR_W = 32;

  // sll r0,r0,0 encodes as all zeros and is the canonical pipeline bubble.
  localparam logic [INSTR_W-1:0] NOP_INSTR_WORD = 32'h0000_0000;

  // IF/ID pipeline register contents, also consumed by decode.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic [31:0]        pc_plus4;
    logic               valid;
  } ifid_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, addresses the I-cache, and loads IF/ID.
// Latency: one cycle from address presentation to IF/ID (synchronous cache read).
// Backpressure: stall freezes IF/ID and replays the in-flight address; redirect flushes with a single bubble.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] icache_rd_addr,
  input  logic [31:0] icache_rd_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  logic [31:0] r_pc_q;        // next address to present in a run cycle
  logic [31:0] r_infl_pc;     // address whose data is on icache_rd_data
  logic        r_infl_valid;  // in-flight word is a real instruction
  ifid_t       r_ifid;
  logic        r_misalign;
  logic [31:0] r_fetch_count;

  logic [31:0] w_target;

  // Redirect targets are forced word-aligned; the low bits only feed the error flag.
  assign w_target = {redirect_pc[31:2], 2'b00};

  // Cache address mux: reset, then redirect, then stall replay, then sequential.
  always_comb begin
    icache_rd_addr = r_pc_q;
    if (rst) begin
      icache_rd_addr = RESET_PC;
    end else if (redirect) begin
      icache_rd_addr = w_target;
    end else if (stall) begin
      icache_rd_addr = r_infl_pc;
    end
  end

  // PC, in-flight tracking, IF/ID register, sticky error and fetch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_q        <= RESET_PC + 32'd4;
      r_infl_pc     <= RESET_PC;
      r_infl_valid  <= 1'b1;
      r_ifid        <= '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};
      r_misalign    <= 1'b0;
      r_fetch_count <= 32'd0;
    end else if (redirect) begin
      // The word in flight is discarded: no branch delay slot.
      r_ifid        <= '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};
      r_infl_pc     <= w_target;
      r_infl_valid  <= 1'b1;
      r_pc_q        <= w_target + 32'd4;
      r_misalign    <= r_misalign | (|redirect_pc[1:0]);
    end else if (!stall) begin
      r_ifid        <= '{instr: icache_rd_data, pc: r_infl_pc,
                         pc_plus4: r_infl_pc + 32'd4, valid: r_infl_valid};
      r_infl_pc     <= r_pc_q;
      r_pc_q        <= r_pc_q + 32'd4;
      if (r_infl_valid) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign ifid_instr    = r_ifid.instr;
  assign ifid_pc       = r_ifid.pc;
  assign ifid_pc_plus4 = r_ifid.pc_plus4;
  assign ifid_valid    = r_ifid.valid;
  assign misalign_err  = r_misalign;
  assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a sequential-stream reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] icache_rd_addr;
  logic [31:0] icache_rd_data;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int checks;
  int failures;

  // Instruction memory, 256 words, indexed by byte address bits [9:2].
  logic [31:0] mem [256];

  // Reference model: what IF/ID should hold and which address is delivered next.
  logic [31:0] m_instr, m_pc, m_pc4, m_next, m_cnt;
  logic        m_valid, m_err;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .icache_rd_addr (icache_rd_addr),
    .icache_rd_data (icache_rd_data),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .ifid_valid     (ifid_valid),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction cache.
  always @(posedge clk) icache_rd_data <= mem[icache_rd_addr[9:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Apply one cycle of control inputs, advance the model by the stream rules, compare after the edge.
  task automatic step(input logic r, input logic s, input logic d, input logic [31:0] rp);
    rst = r; stall = s; redirect = d; redirect_pc = rp;
    #1;
    if (r) check("rd_addr_in_reset", icache_rd_addr, RST_PC);
    if (r) begin
      m_instr = NOP; m_pc = 0; m_pc4 = 0; m_valid = 0;
      m_next = RST_PC; m_err = 0; m_cnt = 0;
    end else if (d) begin
      m_instr = NOP; m_pc = 0; m_pc4 = 0; m_valid = 0;
      m_next = {rp[31:2], 2'b00};
      m_err = m_err | (rp[1:0] != 2'b00);
    end else if (!s) begin
      m_instr = mem[m_next[9:2]];
      m_pc    = m_next;
      m_pc4   = m_next + 32'd4;
      m_valid = 1'b1;
      m_next  = m_next + 32'd4;
      m_cnt   = m_cnt + 32'd1;
    end
    @(negedge clk);
    check("ifid_instr", ifid_instr, m_instr);
    check("ifid_pc", ifid_pc, m_pc);
    check("ifid_pc_plus4", ifid_pc_plus4, m_pc4);
    check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    check("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
    check("fetch_count", fetch_count, m_cnt);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    m_err = 0; m_cnt = 0; m_next = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h2001_000F;
    mem[1] = 32'h2002_0008;
    @(negedge clk);

    // Reset, then first two instructions in order.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("first_instr", ifid_instr, 32'h2001_000F);
    step(0, 0, 0, 0);
    check("second_instr", ifid_instr, 32'h2002_0008);
    check("count_after_two", fetch_count, 32'd2);
    step(0, 0, 0, 0);               // ifid_pc = 0x8
    step(0, 1, 0, 0);               // stall two cycles
    step(0, 1, 0, 0);
    check("stall_hold_pc", ifid_pc, 32'h8);
    step(0, 0, 0, 0);
    check("post_stall_pc", ifid_pc, 32'hC);
    step(0, 0, 0, 0);

    // Redirect to 0x20 after a short restart.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);               // ifid_pc = 0x4
    step(0, 0, 1, 32'h20);
    check("redirect_bubble", {31'd0, ifid_valid}, 32'd0);
    step(0, 0, 0, 0);
    check("redirect_target", ifid_pc, 32'h20);
    step(0, 0, 0, 0);

    // Redirect together with stall; misaligned redirect; wraparound target.
    step(0, 1, 1, 32'h30);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h22);
    step(0, 0, 0, 0);
    check("misalign_target", ifid_pc, 32'h20);
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("wrap_pc", ifid_pc, 32'h0);

    // Reset mid-stream with stall and redirect both asserted.
    step(1, 1, 1, 32'h44);
    step(0, 0, 0, 0);

    // Randomized control traffic.
    for (int n = 0; n < 400; n++) begin
      logic r, s, d;
      logic [31:0] rp;
      r  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 3) == 0);
      d  = ($urandom_range(0, 7) == 0);
      rp = $urandom;
      if (rp[31]) rp = {22'd0, rp[9:0]};
      step(r, s, d, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 32-bit MIPS pipeline. It owns the program counter and drives the instruction cache read address. It absorbs the cache's one-cycle synchronous read latency and loads the IF/ID pipeline register. It supports load-use stalls and jump/branch redirects with no lost or duplicated instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset
- NOP_INSTR, 32'h0000_0000, word loaded into IF/ID on reset and flush (sll r0,r0,0)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit load-use stall; combinational, valid early in the cycle
- redirect  in  1  taken jump/branch; flush and refetch
- redirect_pc  in  32  target byte address, sampled when redirect=1
- icache_rd_addr  out  32  byte address to the instruction cache; combinational
- icache_rd_data  in  32  cache word for the address presented on the previous posedge
- ifid_instr  out  32  IF/ID instruction
- ifid_pc  out  32  byte address of ifid_instr
- ifid_pc_plus4  out  32  ifid_pc + 4
- ifid_valid  out  1  IF/ID holds a real instruction
- misalign_err  out  1  sticky; set when a redirect target has bits [1:0] != 0
- fetch_count  out  32  count of valid words written into IF/ID

## Operation
- Internal registers:
  - pc_q: next address to present
  - infl_pc / infl_valid: address, and validity, of the word currently on icache_rd_data
- Address mux, in priority order:
  - rst → RESET_PC
  - redirect → {redirect_pc[31:2],2'b00}
  - stall → infl_pc (replay the in-flight word)
  - otherwise → pc_q
- Register update rules (per edge):
  - rst: pc_q=RESET_PC+4; infl_pc=RESET_PC; infl_valid=1; IF/ID=NOP_INSTR/0/0/valid 0; misalign_err=0; fetch_count=0.
  - redirect, which wins over stall: IF/ID←NOP_INSTR, valid 0; infl_pc=target; infl_valid=1; pc_q=target+4; misalign_err|=|redirect_pc[1:0].
  - stall without redirect: IF/ID, pc_q, infl_* hold. The replayed address keeps icache_rd_data equal to data(infl_pc).
  - run: IF/ID←{icache_rd_data, infl_pc, infl_pc+4, infl_valid}; infl_pc=pc_q; pc_q=pc_q+4.
- fetch_count increments only on a run edge with infl_valid=1, and wraps modulo 2^32.
- PC arithmetic is 32-bit modulo, so 32'hFFFF_FFFC+4 wraps to 0. There is no range check against cache depth.
- No branch delay slot: the word in flight at redirect is discarded.

## Timing
- Reset values:
  - ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc_plus4=0, ifid_valid=0
  - misalign_err=0, fetch_count=0
  - icache_rd_addr=RESET_PC while rst=1
- Reset to first valid instruction:
  - Reset deasserted after edge E0.
  - ifid_valid=1 with ifid_pc=RESET_PC after edge E1.
  - One new instruction per cycle thereafter.
- Stall of N cycles: IF/ID frozen N cycles. On the first run edge it loads the next sequential word, with zero added bubbles beyond N.
- Redirect in cycle k:
  - ifid_valid=0 after edge k.
  - Target instruction valid after edge k+1.
  - Penalty is exactly one bubble.
- Redirect mid-stall: flush takes effect immediately and the stall is ignored that cycle.
- Reset asserted mid-operation overrides stall and redirect on the same edge.

## Structure
- Shared mips_pkg holds:
  - INSTR_W=32
  - the NOP_INSTR default constant
  - an ifid_t packed struct {instr, pc, pc_plus4, valid}, which decode also consumes
- Single module; no sub-module. The address mux, PC/in-flight registers and counter are small enough to stay flat.

## Test plan
- Reset, cache [0]=2001000F, [4]=20020008 → first valid IF/ID after edge E1: instr 2001000F, pc 0, pc_plus4 4. After E2: instr 20020008, pc 4. fetch_count=2.
- Stall held 2 cycles while ifid_pc=0x8 → ifid_pc stays 0x8 for the stall cycles, then 0xC, 0x10. No address skipped or repeated; fetch_count unaffected while stalled.
- Redirect with redirect_pc=0x20 while ifid_pc=0x4 → next cycle ifid_valid=0 and instr=NOP. Following cycle ifid_pc=0x20, valid=1, then 0x24.
- Redirect and stall asserted together, redirect_pc=0x30 → flush occurs, stall ignored, ifid_pc=0x30 two edges later.
- redirect_pc=0x22 → misalign_err=1 and stays set; fetch proceeds from 0x20. Cleared only by rst.
- rst asserted for one cycle mid-stream with ifid_pc=0x18 → all outputs return to reset values; fetch restarts at RESET_PC. icache_rd_addr=RESET_PC during the reset cycle.
